pit_multi: RTL and testbench
============================

Name: pit_multi

Overview:
- Multi-channel programmable interval timer; parametrised successor of the single-channel 16-bit interval timer.
- NUM_CH independent down-counting channels share one programmable prescaler.
- Each channel has one-shot or repeating mode and a per-channel prescaler select.
- Sits beside the JTAG/config register block. Per-channel interrupt pulses feed the top-level interrupt logic.

Parameters:
- NUM_CH, 4, number of timer channels (1..16)
- CNT_W, 16, width of reload value and channel counter (4..32)
- PRESCALE_W, 8, width of shared prescaler divide value
- CH_W, max(1,$clog2(NUM_CH)), channel-select width (derived; not overridden)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- wr_en  in  1  channel config write strobe
- wr_ch  in  CH_W  channel index for write
- wr_reload  in  CNT_W  reload/period value
- wr_repeat  in  1  1 = auto-reload on expiry, 0 = one-shot
- wr_presc  in  1  1 = channel counts prescaler ticks, 0 = counts every clk
- wr_arm  in  1  1 = start channel, 0 = stop channel
- div_we  in  1  prescaler divide write strobe
- div_value  in  PRESCALE_W  prescaler divide value
- irq  out  NUM_CH  per-channel one-cycle expiry pulse
- active  out  NUM_CH  per-channel armed status
- irq_clr  in  NUM_CH  pending clear, one bit per channel (see Optional Feature)
- irq_pending  out  NUM_CH  sticky pending flags (see Optional Feature)
- irq_any  out  1  OR of irq_pending (see Optional Feature)

Interface: single clock clk; reset rst_n is asynchronous, active-low.

Behaviour:
- Reset (async, any time, including mid-count): all counters, reload, mode bits, active, irq, irq_pending, prescaler counter and divide value go to 0. Every output is 0 during and after reset until programmed.
- Prescaler: presc_cnt free-runs.
  - ptick = (presc_cnt == div_value). On ptick, presc_cnt wraps to 0; otherwise it increments. Period = div_value+1 clk.
  - div_value 0 gives ptick every cycle.
  - div_we loads the divide value and clears presc_cnt the same edge; no ptick is generated on that edge.
- Channel tick: tick = active & (wr_presc_stored ? ptick : 1).
- Config write (wr_en, wr_ch < NUM_CH):
  - On the edge: reload, count and mode bits are loaded; count = wr_reload; active = wr_arm & (wr_reload != 0).
  - A write with wr_ch >= NUM_CH is ignored.
- Counting: on each tick edge, if count > 1, count decrements.
- Expiry: on a tick edge with count == 1:
  - irq[ch] is registered high for exactly the next cycle.
  - Repeat mode: count = reload and the channel stays active.
  - One-shot mode: count = 0 and active = 0.
- Latency: reload N with no prescaler, written at edge E0 → irq high in cycle after edge E0+N. Repeat gives a pulse every N cycles.
- With prescaler: period = N*(div_value+1) cycles. The first period may be short by up to div_value cycles (free-running phase).
- Write and expiry on the same channel in the same edge: the write wins and no irq is produced.
- wr_arm=0 stops the channel immediately; a pending irq pulse already registered still completes.
- Channels are fully independent. Simultaneous expiries assert multiple irq bits in the same cycle.

Optional Feature:
- Macro: PIT_MULTI_STICKY_IRQ_EN.
- When defined:
  - irq_pending[ch] sets on each expiry and holds until irq_clr[ch] is high at an edge.
  - Set beats clear if both occur on the same edge.
  - irq_any = |irq_pending, registered.
- When undefined: irq_pending and irq_any are tied 0 and irq_clr is ignored. Ports remain present.

Test Plan:
- Reset, then ch0 reload=5, repeat=1, presc=0, arm=1 → irq[0] high 1 cycle at 5 cycles after write, then every 5 cycles; active[0]=1 throughout.
- ch1 reload=3, one-shot → single irq[1] pulse 3 cycles after write; active[1] drops to 0 the same edge; no further pulses over 50 cycles.
- div_value=3, ch2 reload=2, presc=1, repeat → irq[2] every 8 cycles after the first (possibly shorter) period.
- ch0 and ch3 both reload=4 written the same edge → irq[0] and irq[3] pulse together. Rewriting ch0 with reload=10 on its expiry edge → no irq[0] that edge; next irq[0] 10 cycles later.
- Write reload=0 with arm=1, and wr_ch=NUM_CH → active stays 0, no irq. Assert rst_n low mid-count → all outputs 0 immediately (async), with no pulse after release.
- With PIT_MULTI_STICKY_IRQ_EN, ch0 expiry → irq_pending[0]=1 and irq_any=1 until irq_clr[0]. Clear coinciding with a new expiry → pending stays 1.

Source files
------------

// File: rtl/pit_multi.sv
// Multi-channel programmable interval timer: NUM_CH down-counting channels sharing one prescaler.
// Optional sticky pending flags are enabled by defining PIT_MULTI_STICKY_IRQ_EN.
module pit_multi #(
  parameter  int NUM_CH     = 4,
  parameter  int CNT_W      = 16,
  parameter  int PRESCALE_W = 8,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [CH_W-1:0]       wr_ch,
  input  logic [CNT_W-1:0]      wr_reload,
  input  logic                  wr_repeat,
  input  logic                  wr_presc,
  input  logic                  wr_arm,
  input  logic                  div_we,
  input  logic [PRESCALE_W-1:0] div_value,
  output logic [NUM_CH-1:0]     irq,
  output logic [NUM_CH-1:0]     active,
  input  logic [NUM_CH-1:0]     irq_clr,
  output logic [NUM_CH-1:0]     irq_pending,
  output logic                  irq_any
);

  logic [PRESCALE_W-1:0] presc_cnt;
  logic [PRESCALE_W-1:0] div_q;
  logic                  ptick;
  logic [NUM_CH-1:0]     wr_sel;
  logic [NUM_CH-1:0]     expire;

  // A divide write restarts the prescaler phase and suppresses the tick on that edge.
  assign ptick = (presc_cnt == div_q) && !div_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
      div_q     <= '0;
    end else if (div_we) begin
      div_q     <= div_value;
      presc_cnt <= '0;
    end else if (ptick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  always_comb begin
    wr_sel = '0;
    if (wr_en && (32'(wr_ch) < NUM_CH))
      wr_sel[wr_ch] = 1'b1;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] reload_q;
    logic             rep_q;
    logic             presc_q;
    logic             act_q;
    logic             irq_q;
    logic             tick;

    assign tick      = act_q & (presc_q ? ptick : 1'b1);
    // A config write on the same edge takes priority over expiry.
    assign expire[g] = tick & (cnt_q == CNT_W'(1)) & ~wr_sel[g];
    assign active[g] = act_q;
    assign irq[g]    = irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q    <= '0;
        reload_q <= '0;
        rep_q    <= 1'b0;
        presc_q  <= 1'b0;
        act_q    <= 1'b0;
        irq_q    <= 1'b0;
      end else if (wr_sel[g]) begin
        cnt_q    <= wr_reload;
        reload_q <= wr_reload;
        rep_q    <= wr_repeat;
        presc_q  <= wr_presc;
        act_q    <= wr_arm & (wr_reload != '0);
        irq_q    <= 1'b0;
      end else begin
        irq_q <= expire[g];
        if (expire[g]) begin
          if (rep_q) begin
            cnt_q <= reload_q;
          end else begin
            cnt_q <= '0;
            act_q <= 1'b0;
          end
        end else if (tick && (cnt_q > CNT_W'(1))) begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

`ifdef PIT_MULTI_STICKY_IRQ_EN
  logic [NUM_CH-1:0] pend_q;
  logic [NUM_CH-1:0] pend_d;
  logic              any_q;

  // Set wins over clear when both land on the same edge.
  assign pend_d = (pend_q & ~irq_clr) | expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      any_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      any_q  <= |pend_d;
    end
  end

  assign irq_pending = pend_q;
  assign irq_any     = any_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = ^irq_clr;
  assign irq_pending    = '0;
  assign irq_any        = 1'b0;
`endif

endmodule

// File: tb/tb_pit_multi.sv
// Self-checking bench for pit_multi: per-cycle behavioural model plus directed literal checks.
module tb_pit_multi;
  localparam int NCH = 5;
  localparam int CW  = 16;
  localparam int PW  = 8;
  localparam int CHW = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           wr_en = 1'b0;
  logic [CHW-1:0] wr_ch = '0;
  logic [CW-1:0]  wr_reload = '0;
  logic           wr_repeat = 1'b0;
  logic           wr_presc = 1'b0;
  logic           wr_arm = 1'b0;
  logic           div_we = 1'b0;
  logic [PW-1:0]  div_value = '0;
  logic [NCH-1:0] irq;
  logic [NCH-1:0] active;
  logic [NCH-1:0] irq_clr = '0;
  logic [NCH-1:0] irq_pending;
  logic           irq_any;

  pit_multi #(.NUM_CH(NCH), .CNT_W(CW), .PRESCALE_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_reload(wr_reload),
    .wr_repeat(wr_repeat), .wr_presc(wr_presc), .wr_arm(wr_arm), .div_we(div_we),
    .div_value(div_value), .irq(irq), .active(active), .irq_clr(irq_clr),
    .irq_pending(irq_pending), .irq_any(irq_any)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: prescaler ticks fall on edges a whole number of periods after the last divide load.
  int       e = 0;
  int       m_ed = 0;
  int       m_div = 0;
  int       m_left [NCH];
  int       m_rel [NCH];
  bit       m_rep [NCH];
  bit       m_presc [NCH];
  bit       m_act [NCH];
  logic [NCH-1:0] m_irq = '0;
  logic [NCH-1:0] m_pend = '0;
  logic           m_any = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    bit pt, wr, tk, ex;
    if (!rst_n) begin
      e = 0; m_ed = 0; m_div = 0; m_irq = '0; m_pend = '0; m_any = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        m_left[c] = 0; m_rel[c] = 0; m_rep[c] = 0; m_presc[c] = 0; m_act[c] = 0;
      end
    end else begin
      e++;
      pt = !div_we && (((e - m_ed) % (m_div + 1)) == 0);
      if (div_we) begin
        m_div = int'(div_value);
        m_ed  = e;
      end
      for (int c = 0; c < NCH; c++) begin
        wr = wr_en && (int'(wr_ch) == c);
        tk = m_act[c] && (m_presc[c] ? pt : 1'b1);
        ex = !wr && tk && (m_left[c] == 1);
        m_irq[c] = ex;
        if (wr) begin
          m_rel[c] = int'(wr_reload); m_left[c] = int'(wr_reload);
          m_rep[c] = wr_repeat; m_presc[c] = wr_presc;
          m_act[c] = wr_arm && (wr_reload != 0);
        end else if (ex) begin
          if (m_rep[c]) m_left[c] = m_rel[c];
          else begin m_left[c] = 0; m_act[c] = 0; end
        end else if (tk && m_left[c] > 1) begin
          m_left[c]--;
        end
`ifdef PIT_MULTI_STICKY_IRQ_EN
        m_pend[c] = (m_pend[c] && !irq_clr[c]) || ex;
`endif
      end
      m_any = |m_pend;
    end
  end

  always @(negedge clk) begin : cmp
    logic [NCH-1:0] m_act_v;
    for (int c = 0; c < NCH; c++) m_act_v[c] = m_act[c];
    chk("irq_model", irq, m_irq);
    chk("active_model", active, m_act_v);
    chk("pending_model", irq_pending, m_pend);
    chk("any_model", irq_any, m_any);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int ch, input int rel, input bit rep, input bit presc, input bit arm);
    wr_en = 1'b1; wr_ch = CHW'(ch); wr_reload = CW'(rel);
    wr_repeat = rep; wr_presc = presc; wr_arm = arm;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    chk("reset_irq", irq, 0);
    chk("reset_active", active, 0);

    // ch0 repeat, period 5
    wr(0, 5, 1, 0, 1);
    cyc(4); chk("ch0_before", irq[0], 0); chk("ch0_active", active[0], 1);
    cyc(1); chk("ch0_first", irq[0], 1);
    cyc(1); chk("ch0_one_cycle", irq[0], 0);
    cyc(4); chk("ch0_second", irq[0], 1);

    // ch1 one-shot, 3
    wr(1, 3, 0, 0, 1);
    cyc(2); chk("ch1_before", irq[1], 0); chk("ch1_armed", active[1], 1);
    cyc(1); chk("ch1_pulse", irq[1], 1); chk("ch1_drop", active[1], 0);
    cyc(50);

    // stop ch0; div 3 and ch2 prescaled reload 2 on the same edge
    wr(0, 5, 1, 0, 0);
    div_we = 1'b1; div_value = 8'd3;
    wr(2, 2, 1, 1, 1);
    div_we = 1'b0;
    cyc(7); chk("ch2_before", irq[2], 0);
    cyc(1); chk("ch2_first", irq[2], 1);
    cyc(7); chk("ch2_gap", irq[2], 0);
    cyc(1); chk("ch2_second", irq[2], 1);
    cyc(20);
    wr(2, 2, 1, 1, 0);

    // ch0 and ch3 aligned expiry, then rewrite ch0 on its expiry edge
    wr(0, 5, 1, 0, 1);
    wr(3, 4, 1, 0, 1);
    cyc(4); chk("ch0_ch3_together", irq & 5'b01001, 5'b01001);
    cyc(4);
    wr(0, 10, 1, 0, 1);
    chk("rewrite_no_irq", irq[0], 0);
    cyc(9); chk("rewrite_before", irq[0], 0);
    cyc(1); chk("rewrite_after10", irq[0], 1);

    // zero reload and out-of-range channel
    wr(4, 0, 1, 0, 1);
    wr(5, 2, 1, 0, 1);
    wr(7, 3, 0, 0, 1);
    chk("ignored_writes_active", active, 5'b01001);
    cyc(10);

    // async reset mid-count
    #2 rst_n = 1'b0;
    #1;
    chk("async_irq", irq, 0);
    chk("async_active", active, 0);
    chk("async_pending", irq_pending, 0);
    chk("async_any", irq_any, 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(20);
    chk("post_reset_active", active, 0);

    // sticky pending
    wr(0, 3, 1, 0, 1);
    cyc(2);
`ifdef PIT_MULTI_STICKY_IRQ_EN
    chk("pend_before", irq_pending[0], 0);
`endif
    cyc(1);
`ifdef PIT_MULTI_STICKY_IRQ_EN
    chk("pend_set", irq_pending[0], 1); chk("any_set", irq_any, 1);
`else
    chk("pend_tied", irq_pending, 0);
`endif
    cyc(2);
    irq_clr = 5'b00001;
    cyc(1);
`ifdef PIT_MULTI_STICKY_IRQ_EN
    chk("pend_set_beats_clr", irq_pending[0], 1);
`endif
    cyc(1);
    irq_clr = '0;
`ifdef PIT_MULTI_STICKY_IRQ_EN
    chk("pend_cleared", irq_pending[0], 0); chk("any_cleared", irq_any, 0);
`else
    chk("any_tied", irq_any, 0);
`endif
    cyc(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
